// File: rtl/layer1_result_serializer.sv
// Purpose: round-robin drain of four 416-bit Layer-1 result streams into a 32-bit AXI-Stream, TLAST per frame.
// Latency: input handshake at cycle t gives the first output beat at t+1; 13 output beats per input beat, zero-bubble handoff.
// Backpressure: out_TREADY=0 holds the current beat stable; inputs accepted only from the current channel when the buffer drains.
// Optional ReLU at capture: define LAYER1_SERIALIZER_RELU_EN to clamp negative lanes to zero.
module layer1_result_serializer #(
   parameter int LANES      = 26,
   parameter int DW         = 16,
   parameter int OUT_W      = 32,
   parameter int NCH        = 4,
   parameter int FRAME_ROWS = 26
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [LANES*DW-1:0]   d0_Data_TDATA,
   input  logic                  d0_Data_TVALID,
   output logic                  d0_Data_TREADY,
   input  logic [LANES*DW-1:0]   d1_Data_TDATA,
   input  logic                  d1_Data_TVALID,
   output logic                  d1_Data_TREADY,
   input  logic [LANES*DW-1:0]   d2_Data_TDATA,
   input  logic                  d2_Data_TVALID,
   output logic                  d2_Data_TREADY,
   input  logic [LANES*DW-1:0]   d3_Data_TDATA,
   input  logic                  d3_Data_TVALID,
   output logic                  d3_Data_TREADY,
   output logic [OUT_W-1:0]      out_TDATA,
   output logic                  out_TVALID,
   input  logic                  out_TREADY,
   output logic                  out_TLAST
);

   localparam int W     = LANES * DW;
   localparam int BEATS = W / OUT_W;
   localparam int BW    = $clog2(BEATS);
   localparam int CW    = $clog2(NCH);
   localparam int RW    = $clog2(FRAME_ROWS);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [RW-1:0]   row_q, row_d;
   logic [W-1:0]    sbuf_q, sbuf_d;
   logic            run_q;

   logic [W-1:0]    in_dat [NCH];
   logic [NCH-1:0]  in_vld;
   logic [NCH-1:0]  in_rdy;
   logic [CW-1:0]   nxt_ch;
   logic            last_beat;

   assign in_dat[0] = d0_Data_TDATA;
   assign in_dat[1] = d1_Data_TDATA;
   assign in_dat[2] = d2_Data_TDATA;
   assign in_dat[3] = d3_Data_TDATA;
   assign in_vld    = {d3_Data_TVALID, d2_Data_TVALID, d1_Data_TVALID, d0_Data_TVALID};

   assign d0_Data_TREADY = in_rdy[0];
   assign d1_Data_TREADY = in_rdy[1];
   assign d2_Data_TREADY = in_rdy[2];
   assign d3_Data_TREADY = in_rdy[3];

   assign nxt_ch    = (ch_q == CW'(NCH-1)) ? '0 : ch_q + CW'(1);
   assign last_beat = (beat_q == BW'(BEATS-1));

   // Capture transform: identity, or per-lane clamp of negatives when ReLU is built in.
   function automatic logic [W-1:0] capture(input logic [W-1:0] w);
      logic [W-1:0] r;
      r = w;
`ifdef LAYER1_SERIALIZER_RELU_EN
      for (int i = 0; i < LANES; i++) begin
         if (w[i*DW+DW-1])
            r[i*DW +: DW] = '0;
      end
`else
`endif
      return r;
   endfunction

   // Output beat is a window into the shift buffer; forced to zero when nothing is presented.
   assign out_TVALID = (state_q == SHIFT);
   assign out_TDATA  = out_TVALID ? sbuf_q[beat_q*OUT_W +: OUT_W] : '0;
   assign out_TLAST  = out_TVALID && last_beat && (ch_q == CW'(NCH-1)) &&
                       (row_q == RW'(FRAME_ROWS-1));

   // Keeps every input TREADY low while reset is held and for the first edge after release.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
         run_q <= 1'b0;
      else
         run_q <= 1'b1;
   end

   // State, counters and shift buffer registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         beat_q  <= '0;
         row_q   <= '0;
         sbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         beat_q  <= beat_d;
         row_q   <= row_d;
         sbuf_q  <= sbuf_d;
      end
   end

   // Next-state: accept from the current channel when empty, step beats on output handshakes,
   // and on the final beat hand straight over to the next channel if it is already valid.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      beat_d  = beat_q;
      row_d   = row_q;
      sbuf_d  = sbuf_q;
      in_rdy  = '0;
      case (state_q)
         IDLE: begin
            in_rdy[ch_q] = run_q;
            if (run_q && in_vld[ch_q]) begin
               sbuf_d  = capture(in_dat[ch_q]);
               beat_d  = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_beat)
               in_rdy[nxt_ch] = out_TREADY;
            if (out_TREADY) begin
               if (!last_beat) begin
                  beat_d = beat_q + BW'(1);
               end else begin
                  ch_d   = nxt_ch;
                  beat_d = '0;
                  if (ch_q == CW'(NCH-1))
                     row_d = (row_q == RW'(FRAME_ROWS-1)) ? '0 : row_q + RW'(1);
                  if (in_vld[nxt_ch])
                     sbuf_d = capture(in_dat[nxt_ch]);
                  else
                     state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
